// File: rtl/memory_unpack.sv
// Serial receiver: hunts a preamble, collects one pack into a ping-pong bank, drains full banks as words.
// Latency: first word o_valid two cycles after the bank fill flag sets, then one word per accepted cycle.
// Backpressure: o_valid & !i_ready holds o_data/o_addr/o_last; a pack arriving with both banks full is dropped.
module memory_unpack #(
    parameter int SIZE_BIT_PACK                  = 1976,
    parameter int SIZE_INPUT_BIT                 = 1,
    parameter int SIZE_OUTPUT_BIT                = 8,
    parameter int LENGTHE_OUTPUT_BIT             = SIZE_BIT_PACK / SIZE_OUTPUT_BIT,
    parameter int SIZE_ADDR_OUTPUT               = $clog2(LENGTHE_OUTPUT_BIT),
    parameter int SISE_PREAMBLE                  = 32,
    parameter logic [SISE_PREAMBLE-1:0] PREAMBLE = 32'h1ACFFC1D,
    parameter int PREAMBLE_MAX_ERR               = 0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic [SIZE_INPUT_BIT-1:0]   i_data,
    output logic [SIZE_OUTPUT_BIT-1:0]  o_data,
    output logic [SIZE_ADDR_OUTPUT-1:0] o_addr,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic                        o_lock,
    output logic                        o_pack_done,
    output logic                        o_overflow,
    output logic [1:0]                  o_fill
);
    localparam int W   = SIZE_OUTPUT_BIT;
    localparam int AW  = SIZE_ADDR_OUTPUT;
    localparam int PW  = SISE_PREAMBLE;
    localparam int BPW = (W > 1) ? $clog2(W) : 1;
    localparam int HW  = $clog2(PW);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(LENGTHE_OUTPUT_BIT - 1);
    localparam logic [BPW-1:0] LAST_POS  = BPW'(W - 1);
    localparam logic [HW-1:0]  HUNT_FULL = HW'(PW - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t         state_q, state_d;
    logic [PW-2:0]  shift_q, shift_d;
    logic [PW-1:0]  shift_nxt;
    logic [HW-1:0]  hunt_cnt_q, hunt_cnt_d;
    logic [BPW-1:0] bit_pos_q, bit_pos_d;
    logic [AW-1:0]  word_idx_q, word_idx_d;
    logic [W-2:0]   word_sr_q, word_sr_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic [1:0]     fill_q, fill_d, fill_seen_q, fill_seen_d;
    logic           pack_done_q, pack_done_d, overflow_q, overflow_d;
    logic           rd_ptr_q, rd_ptr_d, valid_q, valid_d, last_q, last_d;
    logic [AW-1:0]  addr_q, addr_d, rd_addr;
    logic           match, wr_en, rd_en;
    logic [W-1:0]   wr_word;
    logic [1:0]     set_fill, clr_fill;

    logic [W-1:0] bank0_mem [LENGTHE_OUTPUT_BIT];
    logic [W-1:0] bank1_mem [LENGTHE_OUTPUT_BIT];
    logic [W-1:0] bank0_rd_q, bank1_rd_q;

    // Match includes the bit arriving now; hunt_cnt forces a fresh full preamble after every clear.
    always_comb begin
        shift_nxt = {shift_q, i_data[0]};
        match     = (hunt_cnt_q == HUNT_FULL) &&
                    ($countones(shift_nxt ^ PREAMBLE) <= PREAMBLE_MAX_ERR);
        wr_word   = {word_sr_q, i_data[0]};
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hunt_cnt_d  = hunt_cnt_q;
        bit_pos_d   = bit_pos_q;
        word_idx_d  = word_idx_q;
        word_sr_d   = word_sr_q;
        wr_ptr_d    = wr_ptr_q;
        pack_done_d = 1'b0;
        overflow_d  = 1'b0;
        wr_en       = 1'b0;
        set_fill    = 2'b00;
        if (i_valid) begin
            case (state_q)
                HUNT: begin
                    shift_d = shift_nxt[PW-2:0];
                    if (hunt_cnt_q != HUNT_FULL)
                        hunt_cnt_d = hunt_cnt_q + 1'b1;
                    if (match) begin
                        if (fill_q[wr_ptr_q]) begin
                            overflow_d = 1'b1;
                            shift_d    = '0;
                            hunt_cnt_d = '0;
                        end else begin
                            state_d    = COLLECT;
                            bit_pos_d  = '0;
                            word_idx_d = '0;
                        end
                    end
                end
                default: begin
                    word_sr_d = wr_word[W-2:0];
                    if (bit_pos_q == LAST_POS) begin
                        wr_en      = 1'b1;
                        bit_pos_d  = '0;
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == LAST_ADDR) begin
                            state_d            = HUNT;
                            pack_done_d        = 1'b1;
                            set_fill[wr_ptr_q] = 1'b1;
                            wr_ptr_d           = ~wr_ptr_q;
                            shift_d            = '0;
                            hunt_cnt_d         = '0;
                            word_idx_d         = '0;
                        end
                    end else begin
                        bit_pos_d = bit_pos_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Drain side: fill_seen delays the start so o_valid never rises within two cycles of the flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        last_d   = last_q;
        rd_en    = 1'b0;
        rd_addr  = addr_q + 1'b1;
        clr_fill = 2'b00;
        if (!valid_q) begin
            if (fill_q[rd_ptr_q] && fill_seen_q[rd_ptr_q]) begin
                rd_en   = 1'b1;
                rd_addr = '0;
                valid_d = 1'b1;
                addr_d  = '0;
                last_d  = (LAST_ADDR == '0);
            end
        end else if (i_ready) begin
            if (last_q) begin
                valid_d            = 1'b0;
                last_d             = 1'b0;
                addr_d             = '0;
                clr_fill[rd_ptr_q] = 1'b1;
                rd_ptr_d           = ~rd_ptr_q;
            end else begin
                rd_en  = 1'b1;
                addr_d = rd_addr;
                last_d = (rd_addr == LAST_ADDR);
            end
        end
        fill_d      = (fill_q | set_fill) & ~clr_fill;
        fill_seen_d = fill_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= HUNT;
            shift_q     <= '0;
            hunt_cnt_q  <= '0;
            bit_pos_q   <= '0;
            word_idx_q  <= '0;
            word_sr_q   <= '0;
            wr_ptr_q    <= 1'b0;
            fill_q      <= 2'b00;
            fill_seen_q <= 2'b00;
            pack_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hunt_cnt_q  <= hunt_cnt_d;
            bit_pos_q   <= bit_pos_d;
            word_idx_q  <= word_idx_d;
            word_sr_q   <= word_sr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            fill_seen_q <= fill_seen_d;
            pack_done_q <= pack_done_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && !wr_ptr_q) bank0_mem[word_idx_q] <= wr_word;
        if (wr_en &&  wr_ptr_q) bank1_mem[word_idx_q] <= wr_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bank0_rd_q <= '0;
            bank1_rd_q <= '0;
        end else begin
            if (rd_en && !rd_ptr_q) bank0_rd_q <= bank0_mem[rd_addr];
            if (rd_en &&  rd_ptr_q) bank1_rd_q <= bank1_mem[rd_addr];
        end
    end

    assign o_data      = rd_ptr_q ? bank1_rd_q : bank0_rd_q;
    assign o_addr      = addr_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_lock      = (state_q == COLLECT);
    assign o_pack_done = pack_done_q;
    assign o_overflow  = overflow_q;
    assign o_fill      = fill_q;
endmodule

// File: tb/tb_memory_unpack.sv
// Randomised bench for memory_unpack: packs of known bytes go in serially, the output word stream
// is collected and compared with a queue of the bytes sent, in order.
module tb_memory_unpack;
    localparam int NB  = 1976;
    localparam int LEN = 247;
    localparam logic [31:0] PRE = 32'h1ACFFC1D;

    logic       i_clk = 1'b0;
    logic       i_reset, i_valid, i_ready;
    logic [0:0] i_data;
    logic [7:0] o_data0, o_data1;
    logic [7:0] o_addr0, o_addr1;
    logic       o_valid0, o_valid1, o_last0, o_last1, o_lock0, o_lock1;
    logic       o_pack_done0, o_pack_done1, o_overflow0, o_overflow1;
    logic [1:0] o_fill0, o_fill1;

    always #5 i_clk = ~i_clk;

    memory_unpack #(.PREAMBLE_MAX_ERR(0)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
        .o_data(o_data0), .o_addr(o_addr0), .o_valid(o_valid0), .i_ready(i_ready),
        .o_last(o_last0), .o_lock(o_lock0), .o_pack_done(o_pack_done0),
        .o_overflow(o_overflow0), .o_fill(o_fill0));

    memory_unpack #(.PREAMBLE_MAX_ERR(1)) u_dut_err1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
        .o_data(o_data1), .o_addr(o_addr1), .o_valid(o_valid1), .i_ready(i_ready),
        .o_last(o_last1), .o_lock(o_lock1), .o_pack_done(o_pack_done1),
        .o_overflow(o_overflow1), .o_fill(o_fill1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observers: accepted words, level/pulse counters and stall-stability violations.
    logic [16:0] got0[$];
    logic [16:0] got1[$];
    int lock_cnt0 = 0, lock_cnt1 = 0, pd_cnt0 = 0, ov_cnt0 = 0, ov_at = 0, stall_viol = 0;
    int bits_sent = 0;
    logic prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    always @(negedge i_clk) begin
        if (o_valid0 && i_ready) got0.push_back({o_last0, o_addr0, o_data0});
        if (o_valid1 && i_ready) got1.push_back({o_last1, o_addr1, o_data1});
        if (prev_stall && o_valid0 && ({o_last0, o_addr0, o_data0} !== prev_word)) stall_viol++;
        prev_stall = o_valid0 && !i_ready;
        prev_word  = {o_last0, o_addr0, o_data0};
        if (o_lock0) lock_cnt0++;
        if (o_lock1) lock_cnt1++;
        if (o_pack_done0) pd_cnt0++;
        if (o_overflow0) begin
            ov_cnt0++;
            ov_at = bits_sent;
        end
    end

    // 0: ready low, 1: ready high, 2: random ready each cycle
    int rdy_mode = 1;
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    logic [7:0] pay [3][LEN];
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap_max);
        int g;
        g = (gap_max > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, gap_max) : 0;
        repeat (g) begin
            i_valid = 1'b0;
            tick();
        end
        i_valid = 1'b1;
        i_data  = b;
        tick();
        bits_sent++;
        i_valid = 1'b0;
    endtask

    task automatic send_pack(input logic [31:0] pre, input int p, input int nbits, input int gap);
        logic [7:0] byt;
        for (int i = 31; i >= 0; i--) send_bit(pre[i], gap);
        for (int n = 0; n < nbits; n++) begin
            byt = pay[p][n / 8];
            send_bit(byt[7 - (n % 8)], gap);
        end
    endtask

    task automatic fill_pay(input int p, input bit rnd);
        for (int k = 0; k < LEN; k++) pay[p][k] = rnd ? 8'($urandom) : 8'(k % 256);
    endtask

    task automatic push_exp(input int p);
        for (int k = 0; k < LEN; k++) exp_q.push_back(pay[p][k]);
    endtask

    task automatic wait_words(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while (((which != 0) ? got1.size() : got0.size()) < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, (which != 0) ? got1.size() : got0.size(), target);
    endtask

    // Expected word i of the stream: address i mod LEN, last on the final address of each pack.
    task automatic cmp_stream(input string tag, input int base, input int which);
        logic [16:0] e, g;
        int a, idx;
        for (int i = 0; i < exp_q.size(); i++) begin
            a   = i % LEN;
            e   = {a == LEN - 1, 8'(a), exp_q[i]};
            idx = base + i;
            if (which != 0) g = (idx < got1.size()) ? got1[idx] : 17'h1FFFF;
            else            g = (idx < got0.size()) ? got0[idx] : 17'h1FFFF;
            check(tag, {15'd0, g}, {15'd0, e});
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    int base, base1, pd0, lk0, lk1, ov0, cs;
    logic [31:0] bad_pre;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        @(negedge i_clk);
        check("rst_valid", o_valid0, 0);
        check("rst_lock", o_lock0, 0);
        check("rst_fill", o_fill0, 0);
        check("rst_overflow", o_overflow0, 0);
        check("rst_last", o_last0, 0);
        check("rst_pack_done", o_pack_done0, 0);
        check("rst_data_addr", {o_data0, o_addr0}, 0);
        tick();

        // single pack, bytes k mod 256, always ready
        rdy_mode = 1;
        fill_pay(0, 1'b0);
        exp_q.delete();
        push_exp(0);
        base = got0.size();
        pd0  = pd_cnt0;
        send_pack(PRE, 0, NB, 0);
        wait_words("single_count", 0, base + LEN, 3000);
        cmp_stream("single_word", base, 0);
        repeat (20) tick();
        check("single_pack_done", pd_cnt0 - pd0, 1);
        check("single_fill_clear", o_fill0, 0);
        check("single_no_extra", got0.size() - base, LEN);

        // one flipped preamble bit: strict instance ignores, tolerant instance locks
        do_reset();
        fill_pay(1, 1'b1);
        exp_q.delete();
        push_exp(1);
        base  = got0.size();
        base1 = got1.size();
        lk0   = lock_cnt0;
        lk1   = lock_cnt1;
        bad_pre = PRE ^ 32'h0000_0400;
        send_pack(bad_pre, 1, NB, 0);
        wait_words("err1_count", 1, base1 + LEN, 3000);
        cmp_stream("err1_word", base1, 1);
        check("err0_lock_cycles", lock_cnt0 - lk0, 0);
        check("err1_lock_cycles", lock_cnt1 - lk1, NB);
        check("err0_no_words", got0.size() - base, 0);

        // overflow: three packs with ready low, third dropped at its preamble
        do_reset();
        rdy_mode = 0;
        fill_pay(0, 1'b1);
        fill_pay(1, 1'b1);
        fill_pay(2, 1'b1);
        exp_q.delete();
        push_exp(0);
        push_exp(1);
        base = got0.size();
        ov0  = ov_cnt0;
        send_pack(PRE, 0, NB, 0);
        send_pack(PRE, 1, NB, 0);
        repeat (5) tick();
        check("ovf_fill_full", o_fill0, 2'b11);
        cs  = bits_sent;
        lk0 = lock_cnt0;
        send_pack(PRE, 2, NB, 0);
        repeat (5) tick();
        check("ovf_pulse_count", ov_cnt0 - ov0, 1);
        check("ovf_pulse_at_preamble", ov_at - cs, 32);
        check("ovf_no_lock_on_c", lock_cnt0 - lk0, 0);
        check("ovf_no_words_stalled", got0.size() - base, 0);
        rdy_mode = 1;
        wait_words("ovf_drain_count", 0, base + 2 * LEN, 3000);
        cmp_stream("ovf_word", base, 0);
        repeat (50) tick();
        check("ovf_c_absent", got0.size() - base, 2 * LEN);
        check("ovf_fill_clear", o_fill0, 0);

        // backpressure: random ready and random input gaps over two packs
        do_reset();
        rdy_mode = 2;
        fill_pay(0, 1'b1);
        fill_pay(1, 1'b1);
        exp_q.delete();
        push_exp(0);
        push_exp(1);
        base = got0.size();
        pd0  = pd_cnt0;
        lk0  = stall_viol;
        send_pack(PRE, 0, NB, 3);
        send_pack(PRE, 1, NB, 3);
        wait_words("bp_count", 0, base + 2 * LEN, 8000);
        cmp_stream("bp_word", base, 0);
        check("bp_stall_hold", stall_viol - lk0, 0);
        check("bp_pack_done", pd_cnt0 - pd0, 2);

        // reset at payload bit 1000 aborts the pack; next clean pack still arrives
        rdy_mode = 1;
        do_reset();
        fill_pay(0, 1'b1);
        base = got0.size();
        send_pack(PRE, 0, 1000, 0);
        @(negedge i_clk);
        check("abort_lock_before", o_lock0, 1);
        tick();
        i_reset = 1'b1;
        i_valid = 1'b1;
        i_data  = 1'b1;
        tick();
        i_valid = 1'b0;
        @(negedge i_clk);
        check("abort_lock_after", o_lock0, 0);
        check("abort_fill_after", o_fill0, 0);
        tick();
        i_reset = 1'b0;
        tick();
        fill_pay(1, 1'b1);
        exp_q.delete();
        push_exp(1);
        send_pack(PRE, 1, NB, 0);
        wait_words("abort_next_count", 0, base + LEN, 3000);
        cmp_stream("abort_next_word", base, 0);
        repeat (20) tick();
        check("abort_no_extra", got0.size() - base, LEN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
